mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Multi-cycle iterative multiply/divide engine for the EX stage, next to the ALU.
//  Fed by the same operand mux as the ALU (input1/input2).
//  Computes the 2*XLEN product or the quotient/remainder into HI/LO over XLEN+1 busy cycles.
//  Replaces the single-cycle MULT/DIV paths; the pipeline stalls on busy.
// PARAMETERS
//  XLEN   32   operand width; HI/LO width; iteration count
// PORTS
//  clk           in   1     single clock, rising edge
//  rst           in   1     synchronous, active-high reset
//  start         in   1     request; sampled only in IDLE
//  op            in   2     0=MULTU 1=MULT 2=DIVU 3=DIV (sampled with start)
//  input1        in   XLEN  multiplicand / dividend (sampled with start)
//  input2        in   XLEN  multiplier / divisor (sampled with start)
//  busy          out  1     operation in flight (CALC or SIGN)
//  done          out  1     one-cycle pulse; hi/lo/div_by_zero valid
//  hi            out  XLEN  product[2*XLEN-1:XLEN] / remainder
//  lo            out  XLEN  product[XLEN-1:0] / quotient
//  div_by_zero   out  1     set with done when DIV/DIVU had input2==0; held until next done
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0; done=0; hi=0; lo=0; div_by_zero=0. Reset wins over every other event.
//  - Reset mid-operation aborts: no done; hi/lo are cleared to 0, not left partially written.
//  - FSM states: IDLE, CALC, SIGN, DONE.
//  - IDLE: start=1 at edge T latches op, input1, input2 and count=0, then enters CALC.
//    For signed ops, |input1| and |input2| are taken and the result signs are recorded.
//  - CALC: one radix-2 step per edge (shift-add multiply / restoring divide) on magnitudes;
//    count++. After XLEN steps (edges T+1..T+XLEN) -> SIGN.
//  - SIGN (edge T+XLEN+1): apply sign correction, write hi/lo, -> DONE.
//  - DONE: done=1 for exactly one cycle (between edges T+XLEN+1 and T+XLEN+2), busy=0;
//    next edge -> IDLE.
//  - busy=1 exactly in CALC and SIGN, i.e. XLEN+1 cycles.
//  - Latency: start edge T to done high = XLEN+1 edges (33 for XLEN=32).
//  - start outside IDLE (CALC/SIGN/DONE) is ignored; there is no queueing.
//  - Operands are captured at start; input1/input2/op may change freely afterwards.
//  - hi/lo/div_by_zero hold their values between operations; they change only at the SIGN edge or on reset.
//  - MULTU: {hi,lo} = input1*input2, unsigned.
//  - MULT: {hi,lo} = two's-complement 2*XLEN product.
//  - DIVU/DIV: lo = quotient truncated toward zero; hi = remainder, sign follows the dividend;
//    |hi| < |divisor|.
//  - Divide by zero: runs full latency; lo = all ones; hi = input1 (as latched);
//    div_by_zero=1 at done.
//  - DIV overflow (MIN / -1): lo = MIN (0x80000000); hi = 0; div_by_zero=0.
//  - Internal accumulator width: 2*XLEN (+1 bit for the divide remainder); count width $clog2(XLEN)+1.
// TESTING
//  1. MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 edges after
//     start edge; busy high for 33 cycles.
//  2. MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
//  3. DIVU 100/7 -> lo=14, hi=2; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF;
//     DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
//  4. DIV 5/0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1; a following DIVU 9/3 -> lo=3, hi=0,
//     div_by_zero=0.
//  5. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
//  6. Pulse start again at cycle 5 of a MULT -> ignored, single done with the first result.
//     Assert rst at cycle 10 of a DIVU -> busy=0, hi=lo=0, no done.
//     Then MULTU 6*7 -> lo=42, hi=0 at normal latency.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative radix-2 MULTU/MULT/DIVU/DIV engine producing HI/LO; done pulses XLEN+1 edges after start.
// No backpressure or queueing: start is accepted only in IDLE and ignored while busy or during done.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] input1,
    input  logic [XLEN-1:0] input2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            div_by_zero
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [1:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   in1_q, in1_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_lo_q, neg_lo_d;
    logic              neg_hi_q, neg_hi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              dbz_q, dbz_d;

    logic              s1, s2;
    logic [XLEN-1:0]   abs1, abs2;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        in1_d    = in1_q;
        acc_d    = acc_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;

        s1   = op[0] & input1[XLEN-1];
        s2   = op[0] & input2[XLEN-1];
        abs1 = s1 ? -input1 : input1;
        abs2 = s2 ? -input2 : input2;

        // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        // Divide: acc = {remainder, dividend/quotient}; the shifted-out MSB is the trial's extra bit.
        div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
        div_next  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                    : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

        prod_fix = neg_lo_q ? -acc_q : acc_q;
        quo_fix  = neg_lo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_hi_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = op;
                    in1_d    = input1;
                    a_d      = abs1;
                    b_d      = abs2;
                    acc_d    = op[1] ? {{XLEN{1'b0}}, abs1} : {{XLEN{1'b0}}, abs2};
                    neg_lo_d = s1 ^ s2;
                    neg_hi_d = s1;
                    count_d  = '0;
                    busy_d   = 1'b1;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d   = op_q[1] ? div_next : mul_next;
                count_d = count_q + CW'(1);
                if (count_q == LAST_STEP) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                // MIN / -1 needs no special case: the magnitude quotient negates back to MIN.
                if (op_q[1] && (b_q == '0)) begin
                    hi_d  = in1_q;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else if (op_q[1]) begin
                    hi_d  = rem_fix;
                    lo_d  = quo_fix;
                    dbz_d = 1'b0;
                end else begin
                    hi_d  = prod_fix[2*XLEN-1:XLEN];
                    lo_d  = prod_fix[XLEN-1:0];
                    dbz_d = 1'b0;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            in1_q    <= '0;
            acc_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            in1_q    <= in1_d;
            acc_q    <= acc_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed vector bench for mul_div_unit: results, latency, busy width, start-ignore and reset abort.
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] input1;
    logic [31:0] input2;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    int checks;
    int failures;

    mul_div_unit #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .input1      (input1),
        .input2      (input2),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dbz;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Issues one operation and checks latency, busy width, result and the one-cycle done pulse.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input logic ed);
        int          lat;
        int          bcyc;
        logic        busy_at_done;
        logic [31:0] rhi;
        logic [31:0] rlo;
        logic        rdbz;
        lat = -1;
        busy_at_done = 1'bx;
        rhi = 'x;
        rlo = 'x;
        rdbz = 1'bx;
        @(negedge clk);
        start = 1'b1; op = o; input1 = a; input2 = b;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); input1 = $urandom; input2 = $urandom;
        bcyc = busy ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                busy_at_done = busy;
                rhi = hi;
                rlo = lo;
                rdbz = div_by_zero;
                break;
            end
            if (busy) bcyc++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd33);
        chk({tag, "_busy_cycles"}, 64'(bcyc), 64'd33);
        chk({tag, "_busy_at_done"}, {63'd0, busy_at_done}, 64'd0);
        chk({tag, "_hi"}, {32'd0, rhi}, {32'd0, eh});
        chk({tag, "_lo"}, {32'd0, rlo}, {32'd0, el});
        chk({tag, "_dbz"}, {63'd0, rdbz}, {63'd0, ed});
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, {63'd0, done}, 64'd0);
        chk({tag, "_hold_lo"}, {32'd0, lo}, {32'd0, el});
    endtask

    initial begin
        int          ndone;
        int          first_k;
        logic [31:0] shi;
        logic [31:0] slo;

        checks = 0;
        failures = 0;
        //            op     a             b             exp_hi        exp_lo        dbz
        vecs[0]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{2'd1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[3]  = '{2'd2, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[4]  = '{2'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[5]  = '{2'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        vecs[6]  = '{2'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1};
        vecs[7]  = '{2'd2, 32'd9,        32'd3,        32'd0,        32'd3,        1'b0};
        vecs[8]  = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
        vecs[9]  = '{2'd1, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988, 1'b0};
        vecs[10] = '{2'd2, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0};
        vecs[11] = '{2'd2, 32'd0,        32'd0,        32'd0,        32'hFFFFFFFF, 1'b1};
        vecs[12] = '{2'd3, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       1'b0};
        vecs[13] = '{2'd0, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        1'b0};

        rst = 1'b1; start = 1'b0; op = 2'd0; input1 = '0; input2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        chk("reset_dbz", {63'd0, div_by_zero}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dbz);
        end

        // Second start at cycle 5 of a MULT must be dropped.
        ndone = 0; first_k = -1; shi = 'x; slo = 'x;
        @(negedge clk);
        start = 1'b1; op = 2'd1; input1 = 32'hFFFFFFFD; input2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            start = (k == 5);
            op = 2'd0; input1 = 32'd2; input2 = 32'd2;
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (first_k < 0) begin
                    first_k = k; shi = hi; slo = lo;
                end
            end
        end
        start = 1'b0;
        chk("ignore_done_count", 64'(ndone), 64'd1);
        chk("ignore_latency", 64'(first_k), 64'd33);
        chk("ignore_hi", {32'd0, shi}, {32'd0, 32'hFFFFFFFF});
        chk("ignore_lo", {32'd0, slo}, {32'd0, 32'hFFFFFFEB});

        // Reset at cycle 10 of a DIVU aborts it and clears hi/lo.
        @(negedge clk);
        start = 1'b1; op = 2'd2; input1 = 32'd100; input2 = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_hi", {32'd0, hi}, 64'd0);
        chk("abort_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);

        run_op("after_abort", 2'd0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
